// File: rtl/btn_pkg.sv
// Shared types for the push-button event path: event codes carried on the
// event interface and the debounce state machine encoding.
package btn_pkg;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2,
        EVT_LONG    = 2'd3
    } evt_code_e;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input. The reset value
// is a parameter so the flops can come out of reset at the pin's idle level.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw pin through two flops to resolve metastability.
    // NOTE: both stages use non-blocking assignments so q takes the old meta,
    // giving a true two-stage delay instead of collapsing into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_event_rx.sv
// Button conditioner: synchronises and debounces a raw push-button, tracks
// press duration, and offers PRESS / RELEASE / LONG events through a
// single-entry valid/ready register that drops new events under backpressure.
module btn_event_rx
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 500_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_i,
    output logic       level_o,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [1:0] evt_code_o,
    output logic       evt_drop_o
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LONG_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_PRESS_CYCLES);

    btn_state_e        state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [LONG_W-1:0] long_cnt;
    logic              long_fired;

    logic              btn_sync;
    logic              s;
    logic [DEB_W-1:0]  deb_next;
    logic [LONG_W-1:0] long_next;
    logic              deb_done;
    logic              long_hit;
    evt_code_e         new_evt;

    // The flops idle at the released pin level so reset never looks like a press.
    sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (btn_i),
        .q   (btn_sync)
    );

    // Normalised button: 1 = pressed regardless of pin polarity.
    assign s = btn_sync ^ ACTIVE_LOW;

    assign deb_next  = deb_cnt + 1'b1;
    assign long_next = long_cnt + 1'b1;
    assign deb_done  = (deb_next == DEB_MAX);
    assign long_hit  = (long_next == LONG_MAX) && !long_fired;

    // Decode which event (if any) the state machine commits on this edge.
    // NOTE: new_evt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        new_evt = EVT_NONE;
        case (state)
            PRESS_WAIT:   if (s && deb_done)  new_evt = EVT_PRESS;
            PRESSED:      if (long_hit)       new_evt = EVT_LONG;
            RELEASE_WAIT: if (!s && deb_done) new_evt = EVT_RELEASE;
            default:      new_evt = EVT_NONE;
        endcase
    end

    // Debounce state machine with its counters and the registered level.
    // The cycle that first sees s=1 in IDLE already counts as stable cycle one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            deb_cnt    <= '0;
            long_cnt   <= '0;
            long_fired <= 1'b0;
            level_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= DEB_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_done) begin
                        state      <= PRESSED;
                        deb_cnt    <= '0;
                        long_cnt   <= '0;
                        long_fired <= 1'b0;
                        level_o    <= 1'b1;
                    end else begin
                        deb_cnt <= deb_next;
                    end
                end
                PRESSED: begin
                    // Saturate so a very long hold never wraps back into LONG.
                    if (long_cnt != LONG_MAX) long_cnt <= long_next;
                    if (long_hit) long_fired <= 1'b1;
                    if (!s) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= DEB_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    // long_cnt holds here, so a glitch only delays LONG.
                    if (s) begin
                        state   <= PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_done) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                        level_o <= 1'b0;
                    end else begin
                        deb_cnt <= deb_next;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

    // Single-entry event register: a pop in the same cycle frees the slot for
    // the new event; otherwise a new event while full is discarded and flagged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_valid_o <= 1'b0;
            evt_code_o  <= EVT_NONE;
            evt_drop_o  <= 1'b0;
        end else begin
            evt_drop_o <= 1'b0;
            if (new_evt != EVT_NONE) begin
                if (!evt_valid_o || evt_ready_i) begin
                    evt_valid_o <= 1'b1;
                    evt_code_o  <= new_evt;
                end else begin
                    evt_drop_o <= 1'b1;
                end
            end else if (evt_valid_o && evt_ready_i) begin
                evt_valid_o <= 1'b0;
                evt_code_o  <= EVT_NONE;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_rx.sv
// Self-checking bench for btn_event_rx with short debounce/long-press times.
// Expected event codes are queued when stimulus is driven and popped on each
// valid/ready handshake; latencies and corner cases are checked directly.
module tb_btn_event_rx;
    import btn_pkg::*;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic       evt_drop;

    btn_event_rx #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_i       (btn),
        .level_o     (level),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_code_o  (evt_code),
        .evt_drop_o  (evt_drop)
    );

    always #5 clk = ~clk;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         drop_cnt = 0;
    int         pop_cnt  = 0;
    logic [1:0] sb[$];

    typedef struct {
        int         low;
        int         high;
        int         n_exp;
        logic [5:0] codes;   // expected codes, first event in [1:0]
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock: the handshake is decided by the values in place before the
    // rising edge; outputs are then observed at the falling edge.
    task automatic tick();
        logic       hs;
        logic [1:0] code;
        hs   = evt_valid && evt_ready;
        code = evt_code;
        @(negedge clk);
        cyc++;
        if (evt_drop) drop_cnt++;
        if (hs) begin
            pop_cnt++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_evt: got code %0d, no event expected", code);
            end else begin
                check("evt_code", int'(code), int'(sb.pop_front()));
            end
        end
    endtask

    task automatic wait_valid(input string name, input int bound, output int at, output bit lvl_all);
        int n;
        n       = 0;
        lvl_all = 1'b1;
        do begin
            tick();
            n++;
            if (!level) lvl_all = 1'b0;
        end while (!evt_valid && n < bound);
        at = cyc;
        check({name, "_valid"}, int'(evt_valid), 1);
    endtask

    task automatic settle(input string name, input int n);
        repeat (n) tick();
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_level_idle"}, int'(level), 0);
    endtask

    initial begin
        int t0, at, at2, p_cyc, d0, pops0;
        bit lvl;

        vecs[0] = '{low: 3,  high: 3,  n_exp: 0, codes: 6'b00_00_00};
        vecs[1] = '{low: 3,  high: 3,  n_exp: 0, codes: 6'b00_00_00};
        vecs[2] = '{low: 3,  high: 3,  n_exp: 0, codes: 6'b00_00_00};
        vecs[3] = '{low: 4,  high: 12, n_exp: 2, codes: 6'b00_10_01};
        vecs[4] = '{low: 10, high: 12, n_exp: 2, codes: 6'b00_10_01};
        vecs[5] = '{low: 30, high: 12, n_exp: 3, codes: 6'b10_11_01};
        vecs[6] = '{low: 12, high: 12, n_exp: 2, codes: 6'b00_10_01};

        // Reset state
        rst = 1'b1; btn = 1'b1; evt_ready = 1'b1;
        repeat (3) tick();
        check("rst_level", int'(level), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_code", int'(evt_code), 0);
        check("rst_drop", int'(evt_drop), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Clean press and release with latency checks
        sb.push_back(EVT_PRESS);
        btn = 1'b0; t0 = cyc;
        wait_valid("clean_press", 20, at, lvl);
        check_range("clean_press_lat", at - t0, 5, 7);
        check("clean_press_level", int'(level), 1);
        check("clean_press_code", int'(evt_code), 1);
        tick();
        check("clean_press_one_cycle", int'(evt_valid), 0);
        sb.push_back(EVT_RELEASE);
        btn = 1'b1; t0 = cyc;
        wait_valid("clean_rel", 20, at, lvl);
        check_range("clean_rel_lat", at - t0, 5, 7);
        check("clean_rel_level", int'(level), 0);
        settle("clean", 6);

        // Table-driven pulse widths (bounce, minimal press, long)
        for (int v = 0; v < 7; v++) begin
            pops0 = pop_cnt;
            for (int k = 0; k < vecs[v].n_exp; k++) sb.push_back(vecs[v].codes[2*k +: 2]);
            btn = 1'b0;
            repeat (vecs[v].low) tick();
            if (vecs[v].n_exp == 0) check($sformatf("vec%0d_level_low", v), int'(level), 0);
            btn = 1'b1;
            repeat (vecs[v].high) tick();
            check($sformatf("vec%0d_events", v), pop_cnt - pops0, vecs[v].n_exp);
            check($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
            check($sformatf("vec%0d_level", v), int'(level), 0);
        end

        // Long press: PRESS, LONG exactly LONG cycles later, RELEASE
        pops0 = pop_cnt;
        sb.push_back(EVT_PRESS); sb.push_back(EVT_LONG); sb.push_back(EVT_RELEASE);
        btn = 1'b0; t0 = cyc;
        wait_valid("long_press", 20, p_cyc, lvl);
        wait_valid("long_long", 40, at, lvl);
        check("long_lat", at - p_cyc, LONG);
        check("long_level", int'(level), 1);
        while (cyc - t0 < 30) tick();
        btn = 1'b1; t0 = cyc;
        wait_valid("long_rel", 20, at, lvl);
        check_range("long_rel_lat", at - t0, 5, 7);
        settle("long", 6);
        check("long_event_count", pop_cnt - pops0, 3);

        // Backpressure: PRESS held stable, RELEASE dropped
        evt_ready = 1'b0;
        sb.push_back(EVT_PRESS);
        btn = 1'b0;
        wait_valid("bp_press", 20, at, lvl);
        check("bp_code", int'(evt_code), 1);
        d0 = drop_cnt;
        repeat (6) tick();
        btn = 1'b1;
        lvl = 1'b1;
        repeat (12) begin
            tick();
            if (!(evt_valid && evt_code == 2'd1)) lvl = 1'b0;
        end
        check("bp_stable", int'(lvl), 1);
        check("bp_drop_count", drop_cnt - d0, 1);
        check("bp_level", int'(level), 0);
        evt_ready = 1'b1;
        tick();
        check("bp_valid_after_pop", int'(evt_valid), 0);
        check("bp_code_after_pop", int'(evt_code), 0);
        settle("bp", 4);

        // Release glitch: no event, level stays high, LONG delayed by 2
        sb.push_back(EVT_PRESS); sb.push_back(EVT_LONG);
        btn = 1'b0;
        wait_valid("gl_press", 20, p_cyc, lvl);
        repeat (4) tick();
        btn = 1'b1;
        repeat (2) tick();
        btn = 1'b0;
        wait_valid("gl_long", 40, at, lvl);
        check("gl_level_held", int'(lvl), 1);
        check("gl_long_lat", at - p_cyc, LONG + 2);
        sb.push_back(EVT_RELEASE);
        btn = 1'b1;
        settle("gl", 12);

        // Reset mid-press with PRESS pending
        evt_ready = 1'b0;
        btn = 1'b0;
        wait_valid("rst_press", 20, at, lvl);
        d0 = drop_cnt;
        rst = 1'b1;
        tick();
        check("midrst_level", int'(level), 0);
        check("midrst_valid", int'(evt_valid), 0);
        check("midrst_code", int'(evt_code), 0);
        check("midrst_drop", int'(evt_drop), 0);
        rst = 1'b0; t0 = cyc;
        sb.push_back(EVT_PRESS);
        wait_valid("rst_repress", 20, at2, lvl);
        check_range("rst_repress_lat", at2 - t0, 5, 7);
        check("rst_no_drop", drop_cnt - d0, 0);
        evt_ready = 1'b1;
        tick();
        sb.push_back(EVT_RELEASE);
        btn = 1'b1;
        settle("midrst", 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
